// File: rtl/wb_initiator_pkg.sv
// Shared types and widths for the single-outstanding Wishbone command initiator.
package wb_initiator_pkg;

  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } wbi_state_t;

endpackage

// File: rtl/wb_cmd_initiator.sv
// Turns one valid/ready command into one pipelined Wishbone transaction and
// returns data/status on a valid/ready response port, with an optional timeout.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// REQ   | cyc+stb high, waiting for the slave to take the strobe (stall low)
// WAIT  | strobe taken, cyc high, waiting for ack/err
// RESP  | cyc low, response held until resp_ready
module wb_cmd_initiator
  import wb_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W         = 30,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_we_i,
  input  logic [ADDR_W-1:0]  cmd_adr_i,
  input  logic [WB_DW-1:0]   cmd_dat_i,
  input  logic [WB_SELW-1:0] cmd_sel_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [WB_DW-1:0]   resp_dat_o,
  output logic               resp_err_o,
  output logic               resp_timeout_o,
  output logic [ADDR_W-1:0]  wb_adr_o,
  output logic [WB_DW-1:0]   wb_dat_w_o,
  input  logic [WB_DW-1:0]   wb_dat_r_i,
  output logic [WB_SELW-1:0] wb_sel_o,
  output logic               wb_we_o,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  input  logic               wb_stall_i,
  input  logic               wb_ack_i,
  input  logic               wb_err_i
);

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  wbi_state_t         state_q, state_d;
  logic [ADDR_W-1:0]  adr_q, adr_d;
  logic [WB_DW-1:0]   dat_w_q, dat_w_d;
  logic [WB_SELW-1:0] sel_q, sel_d;
  logic               we_q, we_d;
  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic               resp_valid_q, resp_valid_d;
  logic [WB_DW-1:0]   resp_dat_q, resp_dat_d;
  logic               resp_err_q, resp_err_d;
  logic               resp_tmo_q, resp_tmo_d;
  logic [15:0]        cnt_q, cnt_d;

  logic rsp_hit;
  logic capture;
  logic to_hit;

  // An ack/err seen while the strobe is still stalled does not belong to us.
  assign rsp_hit = wb_ack_i | wb_err_i;
  assign capture = ((state_q == REQ) && !wb_stall_i && rsp_hit) ||
                   ((state_q == WAIT) && rsp_hit);
  assign to_hit  = TO_EN && (cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      adr_q        <= '0;
      dat_w_q      <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_dat_q   <= '0;
      resp_err_q   <= 1'b0;
      resp_tmo_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      dat_w_q      <= dat_w_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      resp_valid_q <= resp_valid_d;
      resp_dat_q   <= resp_dat_d;
      resp_err_q   <= resp_err_d;
      resp_tmo_q   <= resp_tmo_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_valid_i) state_d = REQ;
      REQ: begin
        if (capture || to_hit) state_d = RESP;
        else if (!wb_stall_i)  state_d = WAIT;
      end
      WAIT: if (capture || to_hit) state_d = RESP;
      RESP: if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    adr_d        = adr_q;
    dat_w_d      = dat_w_q;
    sel_d        = sel_q;
    we_d         = we_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    resp_valid_d = resp_valid_q;
    resp_dat_d   = resp_dat_q;
    resp_err_d   = resp_err_q;
    resp_tmo_d   = resp_tmo_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          adr_d   = cmd_adr_i;
          dat_w_d = cmd_dat_i;
          sel_d   = cmd_sel_i;
          we_d    = cmd_we_i;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      REQ, WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if ((state_q == REQ) && !wb_stall_i) stb_d = 1'b0;
        if (capture) begin
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = wb_err_i;
          resp_tmo_d   = 1'b0;
          resp_dat_d   = (wb_err_i || we_q) ? '0 : wb_dat_r_i;
        end else if (to_hit) begin
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_tmo_d   = 1'b1;
          resp_dat_d   = '0;
        end
      end
      RESP: if (resp_ready_i) resp_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    cmd_ready_o    = (state_q == IDLE);
    wb_adr_o       = adr_q;
    wb_dat_w_o     = dat_w_q;
    wb_sel_o       = sel_q;
    wb_we_o        = we_q;
    wb_cyc_o       = cyc_q;
    wb_stb_o       = stb_q;
    resp_valid_o   = resp_valid_q;
    resp_dat_o     = resp_dat_q;
    resp_err_o     = resp_err_q;
    resp_timeout_o = resp_tmo_q;
  end

endmodule
